// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer:
// op codes, FSM state encoding, divider defaults, divide-by-zero constants.
// When MULDIV_MADD_EN is defined, the multiply-accumulate op codes (7..10) are live.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int DIV_CYCLES_DEF = 32;

  // Divide by zero leaves the dividend in HI and all-ones in LO.
  localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

  // Two's-complement negate when neg is set; used for magnitudes and result fix-up.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] x);
    return neg ? (~x + 32'd1) : x;
  endfunction

  function automatic logic is_signed_op(input logic [3:0] o);
    return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider, one quotient bit per cycle.
// quotient/remainder expose the current iteration's result so the value is
// valid in the same cycle that done is high.
module div_core
  import muldiv_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        annul,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam logic [5:0] LAST = 6'(DIV_CYCLES - 1);

  logic        run_q;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] quo_n, rem_n;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_n  = ge ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
    quo_n  = {quo_q[30:0], ge};
  end

  assign quotient  = quo_n;
  assign remainder = rem_n;
  assign done      = run_q && (cnt_q == LAST);

  // Iteration registers; annul beats start so a killed op never launches.
  always_ff @(posedge clk) begin
    if (!resetn || annul) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (run_q) begin
      quo_q <= quo_n;
      rem_q <= rem_n;
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q == LAST) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for EX; owns HI/LO and requests a pipeline stall
// until the result lands. Optional MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
//
// state       | meaning
// ST_IDLE     | accepting ops; MTHI/MTLO write here without stalling
// ST_MUL_WAIT | multiplier latency countdown, result written on last count
// ST_DIV_RUN  | div_core iterating, result written when it signals done
// ST_DONE     | HI/LO hold the result; waits out stall_hold so EX cannot reissue
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT    = 2,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        stall_hold,
  output logic        stallreq,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;

  logic        op_is_mul;
  logic        sgn;
  logic [63:0] a_ext, b_ext, product, mul_res;
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem;
  logic        stall_c;

  // Which incoming op codes take the multiplier path.
  always_comb begin
    op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_MADD_EN
    op_is_mul = op_is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
                (op == OP_MSUB) || (op == OP_MSUBU);
`endif
  end

  assign sgn     = is_signed_op(op_q);
  assign a_ext   = {{32{sgn & a_q[31]}}, a_q};
  assign b_ext   = {{32{sgn & b_q[31]}}, b_q};
  assign product = a_ext * b_ext;

  // Value written to {HI,LO} when the multiplier finishes.
  always_comb begin
    mul_res = product;
`ifdef MULDIV_MADD_EN
    if (op_q == OP_MADD || op_q == OP_MADDU)
      mul_res = {hi_q, lo_q} + product;
    else if (op_q == OP_MSUB || op_q == OP_MSUBU)
      mul_res = {hi_q, lo_q} - product;
`endif
  end

  div_core #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start),
    .annul    (flush),
    .dividend (neg_if(is_signed_op(op) & src_a[31], src_a)),
    .divisor  (neg_if(is_signed_op(op) & src_b[31], src_b)),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done)
  );

  // Next-state, HI/LO update and stall request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    div_start = 1'b0;
    stall_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          if (op == OP_MTHI) begin
            hi_d = src_a;
          end else if (op == OP_MTLO) begin
            lo_d = src_a;
          end else if (op_is_mul) begin
            stall_c = 1'b1;
            a_d     = src_a;
            b_d     = src_b;
            op_d    = op;
            cnt_d   = '0;
            state_d = ST_MUL_WAIT;
          end else if (op == OP_DIV || op == OP_DIVU) begin
            stall_c = 1'b1;
            a_d     = src_a;
            b_d     = src_b;
            op_d    = op;
            if (src_b == 32'd0) begin
              hi_d    = src_a;
              lo_d    = DIVZ_LO;
              state_d = ST_DONE;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV_RUN;
            end
          end
        end
      end
      ST_MUL_WAIT: begin
        stall_c = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          {hi_d, lo_d} = mul_res;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DIV_RUN: begin
        stall_c = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (div_done) begin
          hi_d    = neg_if(sgn & a_q[31], div_rem);
          lo_d    = neg_if(sgn & (a_q[31] ^ b_q[31]), div_quo);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || !stall_hold) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign stallreq = stall_c;
  assign busy     = (state_q != ST_IDLE);
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; expected {HI,LO} and stall lengths are
// queued when an op is driven and popped once the op completes.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int TB_MUL_LAT = 2;
  localparam int TB_DIV_CYC = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        flush = 1'b0, stall_hold = 1'b0;
  logic        stallreq, busy;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [63:0] hilo;
    int          stall;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_hilo = '0;

  muldiv_ctrl #(.MUL_LAT(TB_MUL_LAT), .DIV_CYCLES(TB_DIV_CYC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .op_valid  (op_valid),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .stall_hold(stall_hold),
    .stallreq  (stallreq),
    .busy      (busy),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural reference for {HI,LO} after one op.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    logic [63:0] r, q64, rm64, p;
    longint sa, sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    r   = cur;
    case (o)
      OP_MULT:  begin p = sa * sb_; r = p; end
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin q64 = sa / sb_; rm64 = sa % sb_; r = {rm64[31:0], q64[31:0]}; end
      end
      OP_DIVU: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      OP_MTHI: r[63:32] = a;
      OP_MTLO: r[31:0]  = a;
`ifdef MULDIV_MADD_EN
      OP_MADD:  begin p = sa * sb_; r = cur + p; end
      OP_MADDU: r = cur + {32'd0, a} * {32'd0, b};
      OP_MSUB:  begin p = sa * sb_; r = cur - p; end
      OP_MSUBU: r = cur - {32'd0, a} * {32'd0, b};
`endif
      default: r = cur;
    endcase
    return r;
  endfunction

  function automatic int exp_stall(input logic [3:0] o, input logic [31:0] b);
    case (o)
      OP_MULT, OP_MULTU: return TB_MUL_LAT + 1;
      OP_DIV, OP_DIVU:   return (b == 0) ? 1 : TB_DIV_CYC + 1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return TB_MUL_LAT + 1;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, count stallreq-high cycles, compare once it has retired.
  task automatic do_op(input string tag, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    bit   fin;
    e.hilo  = model(o, a, b, m_hilo);
    e.stall = exp_stall(o, b);
    m_hilo  = e.hilo;
    sb.push_back(e);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    n = 0; fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (stallreq) n++;
      else fin = 1'b1;
      if (!fin) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
    e = sb.pop_front();
    check({tag, ".stall"}, 64'(n), 64'(e.stall));
    check({tag, ".hilo"}, {hi_o, lo_o}, e.hilo);
  endtask

  initial begin
    exp_t        e;
    int          n, extra;
    bit          fin;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    // Reset
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.stall", 64'(stallreq), 64'd0);
    check("rst.hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk); #1;

    // Multiplies and divides from the plan, plus divide-by-zero and overflow
    do_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2);
    check("mult.lit", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu.lit", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    do_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div.lit", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu", OP_DIVU, 32'd100, 32'd7);
    do_op("divz", OP_DIVU, 32'h1234, 32'd0);
    do_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf.lit", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
    do_op("divneg", OP_DIV, 32'd17, 32'hFFFF_FFFB);

    // Flush on cycle 10 of a divide: no write, then a clean divide
    do_op("mthi", OP_MTHI, 32'hAAAA, 32'd0);
    do_op("mtlo", OP_MTLO, 32'h5555, 32'd0);
    e.hilo = m_hilo; e.stall = 0;
    sb.push_back(e);
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush.pre_stall", 64'(stallreq), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = 4'd0;
    @(negedge clk);
    e = sb.pop_front();
    check("flush.busy", 64'(busy), 64'd0);
    check("flush.stall", 64'(stallreq), 64'd0);
    check("flush.hilo", {hi_o, lo_o}, e.hilo);
    @(posedge clk); #1;
    do_op("postflush", OP_DIVU, 32'd9, 32'd3);

    // stall_hold in DONE with the op still presented: one write, no reissue
    e.hilo = model(OP_MULT, 32'd3, 32'd4, m_hilo); e.stall = TB_MUL_LAT + 1;
    m_hilo = e.hilo;
    sb.push_back(e);
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
    n = 0; fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (stallreq) n++;
      else fin = 1'b1;
      if (!fin) begin @(posedge clk); #1; end
    end
    stall_hold = 1'b1;
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (stallreq) extra++;
    end
    check("hold.busy_held", 64'(busy), 64'd1);
    stall_hold = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
    repeat (3) begin
      @(negedge clk);
      if (stallreq) extra++;
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    check("hold.stall", 64'(n), 64'(e.stall));
    check("hold.extra", 64'(extra), 64'd0);
    check("hold.hilo", {hi_o, lo_o}, e.hilo);
    check("hold.busy_after", 64'(busy), 64'd0);

    // Accumulate ops (NOP in the default build)
    do_op("madd_hi", OP_MTHI, 32'd0, 32'd0);
    do_op("madd_lo", OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    do_op("maddu", OP_MADDU, 32'd1, 32'd1);
`ifdef MULDIV_MADD_EN
    check("maddu.lit", {hi_o, lo_o}, 64'h0000_0001_0000_0000);
`else
    check("maddu.lit", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFF);
`endif
    do_op("op15", 4'd15, 32'h1111, 32'h2222);

    // Randomised mix
    for (int i = 0; i < 8; i++) begin
      ro = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (i == 5) rb = 32'd0;
      do_op($sformatf("rnd%0d", i), ro, ra, rb);
    end

    // Reset in the middle of a divide drops it and clears HI/LO
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd7;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0; op_valid = 1'b0; op = 4'd0;
    @(posedge clk); #1 resetn = 1'b1;
    m_hilo = '0;
    @(negedge clk);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.stall", 64'(stallreq), 64'd0);
    check("midrst.hilo", {hi_o, lo_o}, m_hilo);
    @(posedge clk); #1;
    do_op("after_rst", OP_MULTU, 32'd6, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
